// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: integer divisor, oversample stage and phase restart.
// Define BAUD_FRAC_EN to build the fractional accumulator for non-integer periods.
module baud_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVS         = 16,
    parameter int OVS_W       = 4,
    parameter int DEFAULT_DIV = 27
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              sync,
    output logic              tick_ovs,
    output logic              tick_bit,
    output logic [OVS_W-1:0]  ovs_cnt
);

    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W:0]   last;
    logic             restart;

    assign restart = load | sync;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_r;
    logic [FRAC_W-1:0] acc;
    logic              extra;

    // P-1 is formed one bit wider so a maximal divisor plus the extra cycle cannot wrap.
    assign last = {1'b0, div_r} + {{DIV_W{1'b0}}, extra} - (DIV_W + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_r <= '0;
            acc    <= '0;
            extra  <= 1'b0;
        end else begin
            if (load)
                frac_r <= div_frac;
            if (restart) begin
                acc   <= '0;
                extra <= 1'b0;
            end else if (tick_ovs) begin
                {extra, acc} <= {1'b0, acc} + {1'b0, frac_r};
            end
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^div_frac;
    assign last        = {1'b0, div_r} - (DIV_W + 1)'(1);
`endif

    // NOTE: the tick decode is a continuous assign, so it cannot infer a latch and is
    // visible in the same cycle as the counter state that produces it.
    assign tick_ovs = en && !restart && ({1'b0, cnt} == last);
    assign tick_bit = tick_ovs && (ovs_cnt == OVS_LAST);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_r <= DIV_RST;
        else if (load)
            div_r <= (div_int < DIV_MIN) ? DIV_MIN : div_int;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ovs_cnt <= '0;
        end else if (restart) begin
            cnt     <= '0;
            ovs_cnt <= '0;
        end else if (tick_ovs) begin
            cnt     <= '0;
            ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
        end else if (en) begin
            cnt     <= cnt + DIV_W'(1);
        end
    end

endmodule
